us_timming_router: RTL

US_TIMMING_ROUTER -- requirements
Module: us_timming_router

---
 rtl/us_timming_router.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/us_timming_router.sv
// us_timming_router
// Routes framed beats from US_CHANNEL upstream inputs into TOTAL_NUM cache
// FIFOs. A sop beat looks up its 24-bit key in a programmable route table. An
// accepted frame locks its slot until eop, so frames never interleave in one
// FIFO. Per-channel counters record dropped and truncated frames.
`timescale 1ns/1ps
module us_timming_router #(
  parameter  int US_CHANNEL = 8,
  parameter  int TOTAL_NUM  = 114,
  parameter  int DATA_W     = 128,
  parameter  int CNT_W      = 16,
  localparam int IDX_W      = $clog2(TOTAL_NUM)
) (
  input  logic                           sys_clk_i,
  input  logic                           rst_n_i,
  input  logic [US_CHANNEL-1:0]          us_valid_i,
  input  logic [US_CHANNEL-1:0]          us_sop_i,
  input  logic [US_CHANNEL-1:0]          us_eop_i,
  input  logic [US_CHANNEL*24-1:0]       us_addr_i,
  input  logic [US_CHANNEL*DATA_W-1:0]   us_data_i,
  input  logic                           cfg_wr_i,
  input  logic [IDX_W-1:0]               cfg_idx_i,
  input  logic [23:0]                    cfg_addr_i,
  input  logic                           cfg_en_i,
  input  logic [TOTAL_NUM-1:0]           cache_prog_full_i,
  output logic [TOTAL_NUM-1:0]           cache_wr_en_o,
  output logic [TOTAL_NUM*DATA_W-1:0]    cache_wr_data_o,
  output logic [US_CHANNEL*CNT_W-1:0]    drop_cnt_o,
  output logic [US_CHANNEL*CNT_W-1:0]    trunc_cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // Route table
  logic [23:0]          key_q [TOTAL_NUM];
  logic [TOTAL_NUM-1:0] en_q;

  // Per-channel frame tracking and statistics
  logic [1:0]       state_q [US_CHANNEL];
  logic [1:0]       state_d [US_CHANNEL];
  logic [IDX_W-1:0] slot_q  [US_CHANNEL];
  logic [IDX_W-1:0] slot_d  [US_CHANNEL];
  logic [CNT_W-1:0] drop_q  [US_CHANNEL];
  logic [CNT_W-1:0] drop_d  [US_CHANNEL];
  logic [CNT_W-1:0] trunc_q [US_CHANNEL];
  logic [CNT_W-1:0] trunc_d [US_CHANNEL];

  // Per-slot lock and registered write port
  logic [TOTAL_NUM-1:0] lock_q, lock_d;
  logic [TOTAL_NUM-1:0] wr_en_q, wr_en_d;
  logic [DATA_W-1:0]    wr_data_q [TOTAL_NUM];
  logic [DATA_W-1:0]    wr_data_d [TOTAL_NUM];

  // Scratch used while walking the channels in priority order
  logic [TOTAL_NUM-1:0] claim;
  logic                 hit;
  logic [IDX_W-1:0]     hit_slot;
  logic [23:0]          addr_c;
  logic [DATA_W-1:0]    data_c;
  logic                 cfg_in_range;

  assign cfg_in_range = ({1'b0, cfg_idx_i} < (IDX_W+1)'(TOTAL_NUM));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Next-state: evaluate channels lowest index first so it wins slot contention
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latches are inferred.
    state_d   = state_q;
    slot_d    = slot_q;
    drop_d    = drop_q;
    trunc_d   = trunc_q;
    lock_d    = lock_q;
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    claim     = '0;
    hit       = 1'b0;
    hit_slot  = '0;
    addr_c    = '0;
    data_c    = '0;
    for (int c = 0; c < US_CHANNEL; c++) begin
      addr_c = us_addr_i[c*24 +: 24];
      data_c = us_data_i[c*DATA_W +: DATA_W];
      if (us_valid_i[c]) begin
        if (us_sop_i[c]) begin
          // A sop while mid-frame closes the old frame as truncated.
          if (state_q[c] != ST_IDLE) begin
            trunc_d[c] = sat_inc(trunc_q[c]);
            if (state_q[c] == ST_PASS) lock_d[slot_q[c]] = 1'b0;
          end
          // Lowest matching index wins: scan downward so the last hit is lowest.
          hit      = 1'b0;
          hit_slot = '0;
          for (int t = TOTAL_NUM - 1; t >= 0; t--) begin
            if (en_q[t] && key_q[t] == addr_c) begin
              hit      = 1'b1;
              hit_slot = IDX_W'(t);
            end
          end
          // Availability uses lock_q, so a slot freed this cycle opens next cycle.
          if (hit && !lock_q[hit_slot] && !claim[hit_slot] && !cache_prog_full_i[hit_slot]) begin
            claim[hit_slot]     = 1'b1;
            wr_en_d[hit_slot]   = 1'b1;
            wr_data_d[hit_slot] = data_c;
            if (us_eop_i[c]) begin
              state_d[c] = ST_IDLE;
            end else begin
              state_d[c]       = ST_PASS;
              slot_d[c]        = hit_slot;
              lock_d[hit_slot] = 1'b1;
            end
          end else begin
            drop_d[c]  = sat_inc(drop_q[c]);
            state_d[c] = us_eop_i[c] ? ST_IDLE : ST_DROP;
          end
        end else begin
          case (state_q[c])
            ST_PASS: begin
              wr_en_d[slot_q[c]]   = 1'b1;
              wr_data_d[slot_q[c]] = data_c;
              if (us_eop_i[c]) begin
                state_d[c]         = ST_IDLE;
                lock_d[slot_q[c]]  = 1'b0;
              end
            end
            ST_DROP: if (us_eop_i[c]) state_d[c] = ST_IDLE;
            default: ;
          endcase
        end
      end
    end
  end

  // State, table and output registers with synchronous active-low reset
  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i) begin
      // NOTE: the route table is cleared on reset because a disabled, zero-key table is part of the reset state.
      key_q     <= '{default: '0};
      en_q      <= '0;
      state_q   <= '{default: ST_IDLE};
      slot_q    <= '{default: '0};
      drop_q    <= '{default: '0};
      trunc_q   <= '{default: '0};
      lock_q    <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q   <= state_d;
      slot_q    <= slot_d;
      drop_q    <= drop_d;
      trunc_q   <= trunc_d;
      lock_q    <= lock_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      if (cfg_wr_i && cfg_in_range) begin
        key_q[cfg_idx_i] <= cfg_addr_i;
        en_q[cfg_idx_i]  <= cfg_en_i;
      end
    end
  end

  assign cache_wr_en_o = wr_en_q;

  for (genvar t = 0; t < TOTAL_NUM; t++) begin : g_slot
    assign cache_wr_data_o[t*DATA_W +: DATA_W] = wr_data_q[t];
  end

  for (genvar c = 0; c < US_CHANNEL; c++) begin : g_chan
    assign drop_cnt_o[c*CNT_W +: CNT_W]  = drop_q[c];
    assign trunc_cnt_o[c*CNT_W +: CNT_W] = trunc_q[c];
  end

endmodule
